// File: rtl/mac_pkg.sv
// Shared defaults, types and helpers for the round-robin MAC scheduler.
package mac_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefOutWidth = 2 * DefWidth + 1;
  localparam int unsigned DefNReq     = 4;
  localparam int unsigned DefIdW      = $clog2(DefNReq);
  localparam int unsigned DefMacLat   = 1;

  typedef logic [DefWidth-1:0]    operand_t;
  typedef logic [DefOutWidth-1:0] result_t;
  typedef logic [DefIdW-1:0]      req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // Increment modulo n, for requester counts that are not a power of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a pointer that advances past each winner.
module rr_arbiter
  import mac_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned ID_W  = DefIdW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o,
  output logic             grant_valid_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [31:0]     cand;

  // No grant while reset is high, so nothing can transfer during reset.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    if (!reset_i) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = 32'(ptr_q) + k;
        if (cand >= N_REQ) begin
          cand = cand - N_REQ;
        end
        if (!grant_valid_o && req_i[cand[ID_W-1:0]]) begin
          grant_valid_o               = 1'b1;
          grant_o[cand[ID_W-1:0]]     = 1'b1;
          grant_idx_o                 = cand[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid_o) begin
      ptr_d = ID_W'(wrap_inc(32'(grant_idx_o), N_REQ));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mac_rr_scheduler.sv
// Shares one registered MAC among N_REQ requesters; tags track each issue through the MAC
// latency and the result comes back as a one-cycle tagged response.
module mac_rr_scheduler
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned OUT_WIDTH = 2 * WIDTH + 1,
  parameter int unsigned N_REQ     = DefNReq,
  parameter int unsigned ID_W      = $clog2(N_REQ),
  parameter int unsigned MAC_LAT   = DefMacLat
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  input  logic [N_REQ*WIDTH-1:0] req_c_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]       mac_a_o,
  output logic [WIDTH-1:0]       mac_b_o,
  output logic [WIDTH-1:0]       mac_c_o,
  output logic                   mac_issue_o,
  input  logic [OUT_WIDTH-1:0]   mac_result_i,
  output logic                   resp_valid_o,
  output logic [ID_W-1:0]        resp_id_o,
  output logic [OUT_WIDTH-1:0]   resp_data_o
);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_i         (req_valid_i),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign req_ready_o = grant;

  logic [WIDTH-1:0] sel_a, sel_b, sel_c;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a_i[i*WIDTH +: WIDTH];
        sel_b = req_b_i[i*WIDTH +: WIDTH];
        sel_c = req_c_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Issue register: operands hold on idle edges, only the issue flag drops.
  logic [WIDTH-1:0] mac_a_q, mac_b_q, mac_c_q;
  logic             issue_q;
  logic [ID_W-1:0]  issue_id_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_c_q    <= '0;
      issue_q    <= 1'b0;
      issue_id_q <= '0;
    end else begin
      issue_q <= grant_valid;
      if (grant_valid) begin
        mac_a_q    <= sel_a;
        mac_b_q    <= sel_b;
        mac_c_q    <= sel_c;
        issue_id_q <= grant_idx;
      end
    end
  end

  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign mac_c_o     = mac_c_q;
  assign mac_issue_o = issue_q;

  // Tag pipe: the MAC samples the issue registers, so its last stage lines up with mac_result.
  logic [MAC_LAT-1:0]           tag_valid_q;
  logic [MAC_LAT-1:0][ID_W-1:0] tag_id_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      tag_valid_q[0] <= issue_q;
      tag_id_q[0]    <= issue_id_q;
      for (int unsigned i = 1; i < MAC_LAT; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_id_q[i]    <= tag_id_q[i-1];
      end
    end
  end

  logic                 resp_valid_q;
  logic [ID_W-1:0]      resp_id_q;
  logic [OUT_WIDTH-1:0] resp_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= tag_valid_q[MAC_LAT-1];
      if (tag_valid_q[MAC_LAT-1]) begin
        resp_id_q   <= tag_id_q[MAC_LAT-1];
        resp_data_q <= mac_result_i;
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed bench: a MAC_LAT=1 and a MAC_LAT=3 scheduler, each driving a registered MAC model.
module tb_mac_rr_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // MAC_LAT = 1 instance
  logic        rst1;
  logic [3:0]  rv1, rr1;
  logic [31:0] ra1, rb1, rc1;
  logic [7:0]  ma1, mb1, mc1;
  logic        mi1, resp_v1;
  logic [16:0] mr1, resp_d1;
  logic [1:0]  resp_id1;

  // MAC_LAT = 3 instance
  logic        rst3;
  logic [3:0]  rv3, rr3;
  logic [31:0] ra3, rb3, rc3;
  logic [7:0]  ma3, mb3, mc3;
  logic        mi3, resp_v3;
  logic [16:0] mr3, resp_d3;
  logic [1:0]  resp_id3;
  logic [16:0] p3 [3];

  mac_rr_scheduler #(.MAC_LAT(1)) u_dut1 (
    .clk_i        (clk),
    .reset_i      (rst1),
    .req_valid_i  (rv1),
    .req_a_i      (ra1),
    .req_b_i      (rb1),
    .req_c_i      (rc1),
    .req_ready_o  (rr1),
    .mac_a_o      (ma1),
    .mac_b_o      (mb1),
    .mac_c_o      (mc1),
    .mac_issue_o  (mi1),
    .mac_result_i (mr1),
    .resp_valid_o (resp_v1),
    .resp_id_o    (resp_id1),
    .resp_data_o  (resp_d1)
  );

  mac_rr_scheduler #(.MAC_LAT(3)) u_dut3 (
    .clk_i        (clk),
    .reset_i      (rst3),
    .req_valid_i  (rv3),
    .req_a_i      (ra3),
    .req_b_i      (rb3),
    .req_c_i      (rc3),
    .req_ready_o  (rr3),
    .mac_a_o      (ma3),
    .mac_b_o      (mb3),
    .mac_c_o      (mc3),
    .mac_issue_o  (mi3),
    .mac_result_i (mr3),
    .resp_valid_o (resp_v3),
    .resp_id_o    (resp_id3),
    .resp_data_o  (resp_d3)
  );

  // Registered MAC datapaths
  always @(posedge clk) mr1 <= 17'(ma1) * 17'(mb1) + 17'(mc1);
  always @(posedge clk) begin
    p3[0] <= 17'(ma3) * 17'(mb3) + 17'(mc3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mr3 = p3[2];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset1();
    rst1 = 1'b1;
    rv1  = 4'b0000;
    cyc();
    rst1 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    rv1  = 4'b1111;
    ra1  = 32'hFFFF_FFFF;
    rb1  = 32'hFFFF_FFFF;
    rc1  = 32'hFFFF_FFFF;
    cyc();
    cyc();
    #1;
    tests_run++;
    if (rr1 !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 0000", rr1);
    end
    tests_run++;
    if (mi1 !== 1'b0 || resp_v1 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valids: got issue=%b resp=%b expected 0 0", mi1, resp_v1);
    end
    tests_run++;
    if (ma1 !== 8'd0 || mb1 !== 8'd0 || mc1 !== 8'd0) begin
      tests_failed++; $display("FAIL reset_mac_ops: got %0d %0d %0d expected 0 0 0", ma1, mb1, mc1);
    end
    tests_run++;
    if (resp_id1 !== 2'd0 || resp_d1 !== 17'd0) begin
      tests_failed++; $display("FAIL reset_resp: got id=%0d data=%0d expected 0 0", resp_id1, resp_d1);
    end
    rst1 = 1'b0;
    rv1  = 4'b0000;
  endtask

  task automatic test_single();
    reset1();
    rv1 = 4'b0001; ra1 = 32'd3; rb1 = 32'd4; rc1 = 32'd5;
    #1;
    tests_run++;
    if (rr1 !== 4'b0001) begin
      tests_failed++; $display("FAIL single_grant: got %b expected 0001", rr1);
    end
    cyc();
    rv1 = 4'b0000; ra1 = 32'd0; rb1 = 32'd0; rc1 = 32'd0;
    #1;
    tests_run++;
    if (mi1 !== 1'b1 || ma1 !== 8'd3 || mb1 !== 8'd4 || mc1 !== 8'd5) begin
      tests_failed++;
      $display("FAIL single_issue: got issue=%b a=%0d b=%0d c=%0d expected 1 3 4 5",
               mi1, ma1, mb1, mc1);
    end
    cyc();
    #1;
    tests_run++;
    if (resp_v1 !== 1'b0 || mi1 !== 1'b0) begin
      tests_failed++; $display("FAIL single_early: got resp=%b issue=%b expected 0 0", resp_v1, mi1);
    end
    cyc();
    #1;
    tests_run++;
    if (resp_v1 !== 1'b1 || resp_id1 !== 2'd0 || resp_d1 !== 17'd17) begin
      tests_failed++;
      $display("FAIL single_resp: got v=%b id=%0d data=%0d expected 1 0 17",
               resp_v1, resp_id1, resp_d1);
    end
    cyc();
    #1;
    tests_run++;
    if (resp_v1 !== 1'b0) begin
      tests_failed++; $display("FAIL single_pulse: got resp=%b expected 0", resp_v1);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_data [4];
    logic [3:0]  exp_grant;
    logic [1:0]  exp_id;
    exp_data = '{17'd2, 17'd5, 17'd8, 17'd11};
    reset1();
    for (int i = 0; i < 4; i++) begin
      ra1[i*8 +: 8] = 8'(i + 1);
      rb1[i*8 +: 8] = 8'd2;
      rc1[i*8 +: 8] = 8'(i);
    end
    for (int k = 0; k < 12; k++) begin
      rv1 = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) begin
        exp_grant = 4'b0001 << (k % 4);
        tests_run++;
        if (rr1 !== exp_grant) begin
          tests_failed++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, rr1, exp_grant);
        end
      end
      if (k >= 3 && k < 11) begin
        exp_id = 2'((k - 3) % 4);
        tests_run++;
        if (resp_v1 !== 1'b1 || resp_id1 !== exp_id || resp_d1 !== exp_data[exp_id]) begin
          tests_failed++;
          $display("FAIL b2b_resp[%0d]: got v=%b id=%0d data=%0d expected 1 %0d %0d",
                   k, resp_v1, resp_id1, resp_d1, exp_id, exp_data[exp_id]);
        end
      end else if (k == 11) begin
        tests_run++;
        if (resp_v1 !== 1'b0) begin
          tests_failed++; $display("FAIL b2b_tail: got resp=%b expected 0", resp_v1);
        end
      end
      cyc();
    end
  endtask

  task automatic test_fairness();
    reset1();
    rv1 = 4'b0100;
    #1;
    tests_run++;
    if (rr1 !== 4'b0100) begin
      tests_failed++; $display("FAIL fair_first: got %b expected 0100", rr1);
    end
    cyc();
    rv1 = 4'b1001;
    #1;
    tests_run++;
    if (rr1 !== 4'b1000) begin
      tests_failed++; $display("FAIL fair_wrap: got %b expected 1000", rr1);
    end
    cyc();
    rv1 = 4'b0001;
    #1;
    tests_run++;
    if (rr1 !== 4'b0001) begin
      tests_failed++; $display("FAIL fair_zero: got %b expected 0001", rr1);
    end
    cyc();
    tests_run++;
    if (rr1 !== 4'b0001) begin
      tests_failed++; $display("FAIL fair_repeat: got %b expected 0001", rr1);
    end
    cyc();
    rv1 = 4'b0000;
  endtask

  task automatic test_max_values();
    reset1();
    rv1 = 4'b1000;
    ra1 = 32'hFF00_0000; rb1 = 32'hFF00_0000; rc1 = 32'hFF00_0000;
    #1;
    tests_run++;
    if (rr1 !== 4'b1000) begin
      tests_failed++; $display("FAIL max_grant: got %b expected 1000", rr1);
    end
    cyc();
    rv1 = 4'b0000;
    cyc();
    cyc();
    tests_run++;
    if (resp_v1 !== 1'b1 || resp_id1 !== 2'd3 || resp_d1 !== 17'd65280) begin
      tests_failed++;
      $display("FAIL max_resp: got v=%b id=%0d data=%0d expected 1 3 65280",
               resp_v1, resp_id1, resp_d1);
    end
  endtask

  task automatic test_reset_midflight();
    reset1();
    rv1 = 4'b0010;
    ra1 = 32'h0000_0700; rb1 = 32'h0000_0700; rc1 = 32'h0000_0700;
    cyc();
    rst1 = 1'b1;
    rv1  = 4'b1111;
    #1;
    tests_run++;
    if (rr1 !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_reset_ready: got %b expected 0000", rr1);
    end
    cyc();
    rst1 = 1'b0;
    rv1  = 4'b1110;
    ra1  = 32'h0000_0200; rb1 = 32'h0000_0300; rc1 = 32'h0000_0100;
    #1;
    tests_run++;
    if (rr1 !== 4'b0010) begin
      tests_failed++; $display("FAIL mid_post_grant: got %b expected 0010", rr1);
    end
    for (int k = 2; k < 7; k++) begin
      if (k > 2) begin
        cyc();
        rv1 = 4'b0000;
        #1;
      end
      tests_run++;
      if (k == 5) begin
        if (resp_v1 !== 1'b1 || resp_id1 !== 2'd1 || resp_d1 !== 17'd7) begin
          tests_failed++;
          $display("FAIL mid_resp: got v=%b id=%0d data=%0d expected 1 1 7",
                   resp_v1, resp_id1, resp_d1);
        end
      end else if (resp_v1 !== 1'b0) begin
        tests_failed++; $display("FAIL mid_no_resp[%0d]: got resp=%b expected 0", k, resp_v1);
      end
    end
  endtask

  task automatic test_mac_lat3();
    rst3 = 1'b1;
    rv3  = 4'b0000;
    cyc();
    rst3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rv3 = 4'b0000;
      ra3 = '0; rb3 = '0; rc3 = '0;
      if (k == 0) begin
        rv3 = 4'b0100;
        ra3 = 32'h0005_0000; rb3 = 32'h0006_0000; rc3 = 32'h0007_0000;
      end else if (k == 1) begin
        rv3 = 4'b0001;
        ra3 = 32'd9; rb3 = 32'd10; rc3 = 32'd11;
      end
      #1;
      if (k == 0 || k == 1) begin
        tests_run++;
        if (rr3 !== ((k == 0) ? 4'b0100 : 4'b0001)) begin
          tests_failed++; $display("FAIL lat3_grant[%0d]: got %b", k, rr3);
        end
      end else begin
        tests_run++;
        if (k == 5) begin
          if (resp_v3 !== 1'b1 || resp_id3 !== 2'd2 || resp_d3 !== 17'd37) begin
            tests_failed++;
            $display("FAIL lat3_resp0: got v=%b id=%0d data=%0d expected 1 2 37",
                     resp_v3, resp_id3, resp_d3);
          end
        end else if (k == 6) begin
          if (resp_v3 !== 1'b1 || resp_id3 !== 2'd0 || resp_d3 !== 17'd101) begin
            tests_failed++;
            $display("FAIL lat3_resp1: got v=%b id=%0d data=%0d expected 1 0 101",
                     resp_v3, resp_id3, resp_d3);
          end
        end else if (resp_v3 !== 1'b0) begin
          tests_failed++; $display("FAIL lat3_idle[%0d]: got resp=%b expected 0", k, resp_v3);
        end
      end
      cyc();
    end
  endtask

  initial begin
    rst1 = 1'b1; rv1 = '0; ra1 = '0; rb1 = '0; rc1 = '0;
    rst3 = 1'b1; rv3 = '0; ra3 = '0; rb3 = '0; rc3 = '0;
    cyc();
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_max_values();
    test_reset_midflight();
    test_mac_lat3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
- Shares one multiply-accumulate datapath (registered A*B+C, WIDTH-bit operands, OUT_WIDTH-bit result) between N_REQ requesters.
- Each cycle, a round-robin arbiter accepts at most one operand triple.
- The accepted triple is issued to the MAC, and an ID tag tracks it through the MAC latency.
- The result is returned as a tagged one-cycle response pulse.

Parameters:
- WIDTH, 8: operand width of A, B, C.
- OUT_WIDTH, 2*WIDTH+1: MAC result width; must be >= 2*WIDTH+1 so max A*B+C never overflows.
- N_REQ, 4: number of requesters (2..16).
- ID_W, $clog2(N_REQ): requester ID width.
- MAC_LAT, 1: MAC latency in edges from sampling mac_a/b/c to result valid on mac_result (>= 1).

Ports:
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, N_REQ: requester i has an operand triple pending.
- req_a, input, N_REQ*WIDTH: packed operand A, slice i belongs to requester i.
- req_b, input, N_REQ*WIDTH: packed operand B.
- req_c, input, N_REQ*WIDTH: packed operand C.
- req_ready, output, N_REQ: one-hot grant; transfer occurs at a rising edge where req_valid[i] & req_ready[i].
- mac_a, output, WIDTH: registered operand A to the MAC.
- mac_b, output, WIDTH: registered operand B to the MAC.
- mac_c, output, WIDTH: registered operand C to the MAC.
- mac_issue, output, 1: registered; mac_a/b/c hold a valid issue.
- mac_result, input, OUT_WIDTH: MAC output, valid MAC_LAT edges after the issue is sampled.
- resp_valid, output, 1: one-cycle pulse, response present.
- resp_id, output, ID_W: requester index of the response.
- resp_data, output, OUT_WIDTH: A*B+C for that request.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - rr pointer = 0.
  - mac_issue, resp_valid and all tag valids = 0.
  - mac_a/b/c, resp_id and resp_data = 0.
  - req_ready = 0 while reset is high.
- Grant (combinational):
  - Search req_valid starting at the pointer, wrapping modulo N_REQ.
  - The first set bit gets req_ready.
  - At most one bit is set; all zero if no request is valid.
  - req_ready[i] never asserts without req_valid[i].
- Pointer: on an accept edge for index g, pointer <= (g+1) mod N_REQ; otherwise it is unchanged.
- Issue (accept edge E0):
  - mac_a/b/c <= slices g of req_a/b/c.
  - mac_issue <= 1; tag pipe stage 0 <= {1, g}.
  - On a non-accept edge: mac_issue <= 0, stage 0 valid <= 0, mac_a/b/c hold.
- Tag pipe:
  - MAC_LAT stages of {valid, id}, shifting every edge.
  - Stage MAC_LAT-1 is aligned with mac_result.
- Response: on each edge, resp_valid <= stage[MAC_LAT-1].valid; when valid, resp_id <= its id and resp_data <= mac_result.
- Latency and throughput:
  - Request accepted at edge E0 gives resp_valid high for exactly one cycle after edge E0+MAC_LAT+1 (2 cycles for MAC_LAT=1).
  - Throughput is 1 accept per cycle; no stalls.
  - Responses return in accept order.
- No response backpressure: consumers must take resp_* on the pulse.
- Requester rules:
  - Operands are sampled only at the accept edge; they may change afterwards.
  - Dropping req_valid before grant is legal (no transfer).
- Single requester repeatedly valid: granted every cycle, since the pointer wraps back to it.
- Reset mid-operation:
  - All in-flight tags are discarded, so no resp_valid for pre-reset accepts.
  - The pointer returns to 0.
  - The first post-reset grant search starts at index 0 on the cycle after reset deasserts.
- Arithmetic is performed by the MAC only; the block never modifies data. resp_data equals mac_result bit-exactly.

Decomposition:
- Package mac_pkg: WIDTH, OUT_WIDTH, N_REQ, ID_W, MAC_LAT defaults; typedef operand_t [WIDTH-1:0], result_t [OUT_WIDTH-1:0], req_id_t [ID_W-1:0]; struct tag_t {valid, id}.
- Sub-module rr_arbiter (N_REQ): req vector in, one-hot grant plus encoded index out, pointer register with advance-on-accept.
- The top level holds the issue registers, the tag pipe and the response register.
- The bench instantiates the existing MAC register unit as the datapath.

Test Plan:
- Reset, then req_valid=0001 with A=3, B=4, C=5 for one cycle -> req_ready=0001 that cycle; mac_issue one cycle later; resp_valid pulse 2 cycles after accept with resp_id=0, resp_data=17.
- All four req_valid held high for 8 cycles, operands (i+1, 2, i) -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses in the same order with data 2,5,8,11 repeating; resp_valid continuous.
- Pointer fairness: grant index 2, then req_valid=1001 -> index 3 granted before 0; then only req 0 valid -> granted next cycle.
- Max values, WIDTH=8: A=B=C=255 -> resp_data=65280 in 17 bits, no truncation.
- Reset mid-flight: accept on req 1, assert reset the next cycle for 1 cycle -> no resp_valid ever for that request; after release, req_valid=1110 grants index 1 first (pointer 0).
- MAC_LAT=3 build, back-to-back accepts from req 2 then req 0 -> resp_valid 4 cycles after each accept; ids 2 then 0; data matches the model.
